// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 4-digit 7-segment scan controller.
package seg7_pkg;

    // Segment bit positions inside SEG (active-low pins)
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Pin levels that turn everything dark
    localparam logic [3:0] DIG_OFF = 4'b1111;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // One complete display image: four nibbles, decimal points and blank mask
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_rec_t;

    localparam disp_rec_t DISP_RESET = '{value: 16'h0000, dp: 4'b0000, blank: 4'b1111};

    // Clock cycles per digit slot for the requested full-frame refresh rate
    function automatic int unsigned slot_cycles(input int unsigned clk_hz,
                                                input int unsigned refresh_hz);
        return clk_hz / (refresh_hz * 4);
    endfunction

    // Hex nibble to active-low segments a..g (bit 0 = a)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit-slot timebase: slot counter, digit index, frame pulse and per-slot on-time.
module seg7_slot_timer #(
    parameter int unsigned SLOT_CYC = 20,
    parameter int unsigned GUARD    = 2,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       brightness,
    output logic [CNT_W-1:0] slot_cnt,
    output logic [1:0]       digit_idx,
    output logic             frame_tick,
    output logic [CNT_W-1:0] on_len
);

    localparam int unsigned      PROD_W   = CNT_W + 4;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SLOT_CYC - 2);

    logic [PROD_W-1:0] on_prod;

    // On-time product sized with 4 spare bits so (SLOT_CYC-GUARD)*8 cannot overflow
    always_comb begin
        on_prod = PROD_W'(SLOT_CYC - GUARD) * (PROD_W'(brightness) + PROD_W'(1));
    end

    // Slot counter wraps each slot and steps the digit index 0..3
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_cnt == LAST) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            slot_cnt  <= slot_cnt + CNT_W'(1);
        end
    end

    // Frame pulse is registered one cycle early so it is high exactly during the last cycle of digit 3
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (slot_cnt == PRE_LAST) && (digit_idx == 2'd3);
        end
    end

    // Brightness is sampled once per slot, on the slot's first cycle, and held as on_len
    always_ff @(posedge clk) begin
        if (rst) begin
            on_len <= '0;
        end else if (slot_cnt == '0) begin
            on_len <= CNT_W'(on_prod >> 3);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment controller with tear-free updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned GUARD      = 16
) (
    input  logic        FPGA_CLK,
    input  logic        FPGA_RST,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic [2:0]  brightness,
    output logic        upd_pending,
    output logic        frame_tick,
    output logic [3:0]  DIG,
    output logic [7:0]  SEG
);

    localparam int unsigned SLOT_CYC = slot_cycles(CLK_HZ, REFRESH_HZ);
    localparam int unsigned CNT_W    = $clog2(SLOT_CYC + 1);

    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] on_len;
    logic [1:0]       digit_idx;
    logic [CNT_W:0]   on_end;
    logic             in_window;
    logic [3:0]       nib;
    logic             digit_dp;
    logic             digit_blank;
    logic [7:0]       seg_next;

    disp_rec_t wr_rec;
    disp_rec_t shadow;
    disp_rec_t display;

    seg7_slot_timer #(
        .SLOT_CYC (SLOT_CYC),
        .GUARD    (GUARD),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk        (FPGA_CLK),
        .rst        (FPGA_RST),
        .brightness (brightness),
        .slot_cnt   (slot_cnt),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick),
        .on_len     (on_len)
    );

    // Bundle the host inputs into one display image
    always_comb begin
        wr_rec = '{value: wr_data, dp: dp_in, blank: blank_in};
    end

    // Shadow always tracks the last write; the display copy only changes at frame wrap.
    // A write landing on the wrap cycle bypasses the shadow so it is never reported pending.
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            shadow      <= DISP_RESET;
            display     <= DISP_RESET;
            upd_pending <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= wr_rec;
            end
            if (frame_tick) begin
                display     <= wr_en ? wr_rec : shadow;
                upd_pending <= 1'b0;
            end else if (wr_en) begin
                upd_pending <= 1'b1;
            end
        end
    end

    // Select the current digit's data and decide whether it is inside its lit window
    always_comb begin
        nib         = display.value[{digit_idx, 2'b00} +: 4];
        digit_dp    = display.dp[digit_idx];
        digit_blank = display.blank[digit_idx];
        on_end      = (CNT_W + 1)'(GUARD) + (CNT_W + 1)'(on_len);
        in_window   = (slot_cnt >= CNT_W'(GUARD)) && ({1'b0, slot_cnt} < on_end);
        seg_next                 = SEG_OFF;
        seg_next[SEG_G:SEG_A]    = hex_to_seg(nib);
        seg_next[SEG_DP]         = ~digit_dp;
    end

    // Registered pin stage: one digit low with its segments, or everything dark
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            DIG <= DIG_OFF;
            SEG <= SEG_OFF;
        end else if (in_window && !digit_blank) begin
            DIG <= ~(4'b0001 << digit_idx);
            SEG <= seg_next;
        end else begin
            DIG <= DIG_OFF;
            SEG <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a cycle-count based reference model.
module tb_seg7_scan_ctrl;

    localparam int SLOT = 20;
    localparam int GRD  = 2;
    localparam logic [7:0] HEX_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [2:0]  brightness = 3'd7;
    logic        upd_pending;
    logic        frame_tick;
    logic [3:0]  DIG;
    logic [7:0]  SEG;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    seg7_scan_ctrl #(
        .CLK_HZ     (800),
        .REFRESH_HZ (10),
        .GUARD      (GRD)
    ) dut (
        .FPGA_CLK    (clk),
        .FPGA_RST    (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .brightness  (brightness),
        .upd_pending (upd_pending),
        .frame_tick  (frame_tick),
        .DIG         (DIG),
        .SEG         (SEG)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position in the frame comes from cycles elapsed since reset
    bit          mvalid = 0;
    int          t;
    int          onlen;
    logic [15:0] m_val, s_val;
    logic [3:0]  m_dp, s_dp, m_bl, s_bl;
    logic [3:0]  exp_dig;
    logic [7:0]  exp_seg;
    logic        exp_pend, exp_tick;

    always @(posedge clk) begin
        int slot, dg, nibv;
        if (rst) begin
            mvalid = 1; t = 0; onlen = 0;
            m_val = 0; m_dp = 0; m_bl = 4'hF;
            s_val = 0; s_dp = 0; s_bl = 4'hF;
            exp_dig = 4'hF; exp_seg = 8'hFF; exp_pend = 0; exp_tick = 0;
        end else if (mvalid) begin
            slot = t % SLOT;
            dg   = (t / SLOT) % 4;
            if (slot >= GRD && slot < GRD + onlen && !m_bl[dg]) begin
                exp_dig = 4'hF ^ (4'b0001 << dg);
                nibv    = (m_val >> (4 * dg)) & 15;
                exp_seg = m_dp[dg] ? (HEX_TAB[nibv] & 8'h7F) : HEX_TAB[nibv];
            end else begin
                exp_dig = 4'hF;
                exp_seg = 8'hFF;
            end
            if (t % (4 * SLOT) == 4 * SLOT - 1) begin
                if (wr_en) begin m_val = wr_data; m_dp = dp_in; m_bl = blank_in; end
                else begin m_val = s_val; m_dp = s_dp; m_bl = s_bl; end
                exp_pend = 0;
            end else if (wr_en) begin
                exp_pend = 1;
            end
            if (wr_en) begin s_val = wr_data; s_dp = dp_in; s_bl = blank_in; end
            if (slot == 0) onlen = ((SLOT - GRD) * (int'(brightness) + 1)) / 8;
            t++;
            exp_tick = (t % (4 * SLOT)) == 4 * SLOT - 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("dig", DIG, exp_dig);
            chk("seg", SEG, exp_seg);
            chk("upd_pending", upd_pending, exp_pend);
            chk("frame_tick", frame_tick, exp_tick);
        end
    end

    // Frame observation results
    int         o_cnt[4], o_first[4], o_last[4];
    logic [7:0] o_seg[4];
    int         o_pend, o_bad;

    task automatic wait_tick();
        bit found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) found = 1;
        end
        if (!found) chk("wait_tick_timeout", 0, 1);
    endtask

    // Called at the negedge where frame_tick is high; records what the next frame shows
    task automatic observe_frame();
        logic [3:0] sel;
        for (int d = 0; d < 4; d++) begin
            o_cnt[d] = 0; o_first[d] = -1; o_last[d] = -1; o_seg[d] = 8'hFF;
        end
        o_pend = 0; o_bad = 0;
        @(negedge clk);
        wr_en = 0;
        for (int k = 0; k < 4 * SLOT; k++) begin
            @(negedge clk);
            if (upd_pending) o_pend++;
            if (DIG != 4'hF) begin
                sel = 4'hF ^ (4'b0001 << (k / SLOT));
                if (DIG != sel) o_bad++;
                else begin
                    o_cnt[k / SLOT]++;
                    if (o_first[k / SLOT] < 0) o_first[k / SLOT] = k % SLOT;
                    o_last[k / SLOT] = k % SLOT;
                    o_seg[k / SLOT]  = SEG;
                end
            end
        end
    endtask

    task automatic do_write(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        @(negedge clk);
        wr_data = v; dp_in = dp; blank_in = bl; wr_en = 1;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic dark_run(input string name, input int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (DIG !== 4'hF || SEG !== 8'hFF || upd_pending !== 1'b0) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        int c0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dig", DIG, 4'hF);
        chk("rst_seg", SEG, 8'hFF);
        chk("rst_pend", upd_pending, 0);
        chk("rst_tick", frame_tick, 0);
        rst = 0;
        dark_run("idle_dark", 200);
        wait_tick(); c0 = cyc;
        wait_tick();
        chk("tick_period", cyc - c0, 80);

        // Basic write at full brightness
        do_write(16'h1A30, 4'h0, 4'h0);
        chk("pend_after_write", upd_pending, 1);
        wait_tick();
        chk("pend_at_tick", upd_pending, 1);
        observe_frame();
        chk("b7_cnt0", o_cnt[0], 18);
        chk("b7_first0", o_first[0], 2);
        chk("b7_last0", o_last[0], 19);
        chk("b7_seg0", o_seg[0], 8'hC0);
        chk("b7_seg1", o_seg[1], 8'hB0);
        chk("b7_seg2", o_seg[2], 8'h88);
        chk("b7_seg3", o_seg[3], 8'hF9);
        chk("b7_bad", o_bad, 0);
        chk("b7_pend", o_pend, 0);

        // Brightness 3 then 0
        wait_tick();
        brightness = 3'd3;
        observe_frame();
        chk("b3_cnt_sum", o_cnt[0] + o_cnt[1] + o_cnt[2] + o_cnt[3], 36);
        chk("b3_cnt2", o_cnt[2], 9);
        chk("b3_last1", o_last[1], 10);
        wait_tick();
        brightness = 3'd0;
        observe_frame();
        chk("b0_cnt_sum", o_cnt[0] + o_cnt[1] + o_cnt[2] + o_cnt[3], 8);
        chk("b0_first3", o_first[3], 2);
        chk("b0_last3", o_last[3], 3);

        // Blank digit 2, decimal point on digit 0
        brightness = 3'd7;
        do_write(16'h1A30, 4'b0001, 4'b0100);
        wait_tick();
        observe_frame();
        chk("blank_cnt2", o_cnt[2], 0);
        chk("dp_seg0", o_seg[0], 8'h40);
        chk("blank_cnt0", o_cnt[0], 18);

        // Write exactly on the frame-wrap cycle
        wait_tick();
        wr_data = 16'hBEEF; dp_in = 4'h0; blank_in = 4'h0; wr_en = 1;
        observe_frame();
        chk("wrap_pend", o_pend, 0);
        chk("wrap_seg0", o_seg[0], 8'h8E);
        chk("wrap_seg3", o_seg[3], 8'h83);

        // Two writes in one frame: last one wins
        do_write(16'h1111, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        do_write(16'h2222, 4'h0, 4'h0);
        wait_tick();
        observe_frame();
        chk("lastwin_seg0", o_seg[0], 8'hA4);
        chk("lastwin_seg3", o_seg[3], 8'hA4);

        // Reset while digit 0 is lit with a write pending
        do_write(16'h3333, 4'h0, 4'h0);
        @(negedge clk);
        chk("pre_rst_dig", DIG, 4'b1110);
        chk("pre_rst_pend", upd_pending, 1);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_dig", DIG, 4'hF);
        chk("mid_rst_seg", SEG, 8'hFF);
        @(negedge clk);
        rst = 0;
        dark_run("post_rst_dark", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
